uart_arb_ctrl: RTL and testbench

UART_ARB_CTRL -- requirements
Module: uart_arb_ctrl

---
 rtl/uart_arb_ctrl.sv | 175 +++++++++++++++++
 tb/tb_uart_arb_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_arb_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_arb_ctrl
// Brief    : Shares one register-mapped UART between N transmit requesters
//            and a single receive consumer, alternating RX and TX service.
// Revision : 1.0 - initial release
// ============================================================================
module uart_arb_ctrl #(
    parameter int NumReq       = 2,
    parameter int SettleCycles = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NumReq-1:0]      req_valid,
    input  logic [NumReq-1:0][7:0] req_data,
    output logic [NumReq-1:0]      req_ready,
    output logic                   rx_valid,
    output logic [7:0]             rx_data,
    input  logic                   rx_ready,
    output logic [3:0]             uart_addr,
    output logic [7:0]             uart_wdata,
    output logic                   uart_strobe,
    input  logic [7:0]             uart_rdata
);

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

    localparam logic [3:0]      c_ADDR_RX_STAT = 4'h0;
    localparam logic [3:0]      c_ADDR_RX_POP  = 4'h1;
    localparam logic [3:0]      c_ADDR_TX_DATA = 4'h3;
    localparam logic [3:0]      c_ADDR_TX_STAT = 4'h4;
    localparam logic [CntW-1:0] c_SETTLE_LAST  = CntW'(SettleCycles - 1);
    localparam logic [PtrW-1:0] c_PTR_LAST     = PtrW'(NumReq - 1);
    localparam logic [NumReq-1:0] c_ONE        = {{(NumReq-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_POLL_RX  = 4'd1,
        S_CHK_RX   = 4'd2,
        S_READ_RX  = 4'd3,
        S_CAP_RX   = 4'd4,
        S_POLL_TX  = 4'd5,
        S_CHK_TX   = 4'd6,
        S_WRITE_TX = 4'd7,
        S_SETTLE   = 4'd8
    } state_t;

    state_t            state_q;
    logic              strobe_q;
    logic [3:0]        addr_q;
    logic [7:0]        wdata_q;
    logic [NumReq-1:0] req_ready_q;
    logic              rx_valid_q;
    logic [7:0]        rx_data_q;
    logic [PtrW-1:0]   rr_ptr_q;
    logic [PtrW-1:0]   grant_q;
    logic [PtrW-1:0]   grant_d;
    logic              last_tx_q;
    logic [CntW-1:0]   cnt_q;

    // Rotate the request vector so bit 0 is rr_ptr, then take the lowest set bit.
    logic [2*NumReq-1:0] req_dbl;
    logic [2*NumReq-1:0] req_rot;
    logic                found;
    int                  sum;

    always_comb begin
        req_dbl = {req_valid, req_valid};
        req_rot = req_dbl >> rr_ptr_q;
        grant_d = rr_ptr_q;
        found   = 1'b0;
        sum     = 0;
        for (int k = 0; k < NumReq; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = int'(rr_ptr_q) + k;
                if (sum >= NumReq) begin
                    sum = sum - NumReq;
                end
                grant_d = PtrW'(sum);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            strobe_q    <= 1'b0;
            addr_q      <= 4'h0;
            wdata_q     <= 8'h00;
            req_ready_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            last_tx_q   <= 1'b1;
            cnt_q       <= '0;
        end else begin
            strobe_q    <= 1'b0;
            req_ready_q <= '0;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rx_valid_q && (last_tx_q || !(|req_valid))) begin
                        state_q   <= S_POLL_RX;
                        last_tx_q <= 1'b0;
                        strobe_q  <= 1'b1;
                        addr_q    <= c_ADDR_RX_STAT;
                    end else if (|req_valid) begin
                        state_q   <= S_POLL_TX;
                        last_tx_q <= 1'b1;
                        strobe_q  <= 1'b1;
                        addr_q    <= c_ADDR_TX_STAT;
                        grant_q   <= grant_d;
                    end
                end
                S_POLL_RX: state_q <= S_CHK_RX;
                S_CHK_RX: begin
                    if (uart_rdata[0]) begin
                        state_q  <= S_READ_RX;
                        strobe_q <= 1'b1;
                        addr_q   <= c_ADDR_RX_POP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ_RX: state_q <= S_CAP_RX;
                S_CAP_RX: begin
                    rx_data_q  <= uart_rdata;
                    rx_valid_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                S_POLL_TX: state_q <= S_CHK_TX;
                S_CHK_TX: begin
                    // A requester that withdrew while we polled is skipped silently.
                    if (uart_rdata[0] && req_valid[grant_q]) begin
                        state_q     <= S_WRITE_TX;
                        strobe_q    <= 1'b1;
                        addr_q      <= c_ADDR_TX_DATA;
                        wdata_q     <= req_data[grant_q];
                        req_ready_q <= c_ONE << grant_q;
                        rr_ptr_q    <= (grant_q == c_PTR_LAST) ? '0 : grant_q + 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WRITE_TX: begin
                    state_q <= S_SETTLE;
                    cnt_q   <= c_SETTLE_LAST;
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign uart_strobe = strobe_q;
    assign uart_addr   = addr_q;
    assign uart_wdata  = wdata_q;
    assign req_ready   = req_ready_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_arb_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_arb_ctrl
// Brief    : Directed and randomized bench with a behavioural UART and
//            requester/consumer model for uart_arb_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_arb_ctrl;

    localparam int NREQ   = 3;
    localparam int SETTLE = 3;
    localparam int PW     = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0][7:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic [3:0]           uart_addr;
    logic [7:0]           uart_wdata;
    logic                 uart_strobe;
    logic [7:0]           uart_rdata;

    always #5 clk = ~clk;

    uart_arb_ctrl #(.NumReq(NREQ), .SettleCycles(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_strobe(uart_strobe),
        .uart_rdata(uart_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural world: UART internals, requester queues, consumer expectations
    logic [7:0]      rxq[$];
    logic [7:0]      exp_rx[$];
    logic [7:0]      txq[NREQ][$];
    logic [7:0]      wlog[$];
    logic [3:0]      alog[$];
    logic [NREQ-1:0] en;
    logic [PW-1:0]   model_ptr, exp_grant;
    logic [7:0]      pend_rsp, last_rx_byte, prev_rxd;
    bit              pend_v, rx_stuck, withdraw_on_poll, inject_rx;
    bit              prev_rxv, prev_hs, after_write;
    int              tx_mode, tx_block, rxr_mode, idle_run;
    int              n_writes, n_polls_tx, n_polls_rx, n_reads, n_rx_got, rxv_cycles;
    int              polls_at_first_write;

    // First requester at or after the pointer, wrapping around.
    function automatic logic [PW-1:0] rr_expect(input logic [NREQ-1:0] v, input logic [PW-1:0] p);
        logic [NREQ-1:0] sh;
        int j;
        for (int i = 0; i < NREQ; i++) begin
            j  = (int'(p) + i) % NREQ;
            sh = v >> j;
            if (sh[0]) return PW'(j);
        end
        return p;
    endfunction

    task automatic observe();
        logic [NREQ-1:0] onehot_exp;
        logic [7:0]      b;
        bit              txbit, hs;
        if (uart_strobe) begin
            alog.push_back(uart_addr);
            chk("uart_addr_legal", 32'(uart_addr inside {4'h0, 4'h1, 4'h3, 4'h4}), 32'd1);
            if (after_write) chk("settle_gap", 32'(idle_run >= SETTLE), 32'd1);
            after_write = 1'b0;
            idle_run    = 0;
            case (uart_addr)
                4'h0: begin
                    n_polls_rx++;
                    pend_rsp = {7'($urandom), (rx_stuck || rxq.size() > 0)};
                    pend_v   = 1'b1;
                end
                4'h1: begin
                    n_reads++;
                    chk("no_rx_overwrite", 32'(rx_valid), 32'd0);
                    chk("rx_pop_nonempty", 32'(rx_stuck || rxq.size() != 0), 32'd1);
                    b = (rx_stuck || rxq.size() == 0) ? 8'($urandom) : rxq.pop_front();
                    exp_rx.push_back(b);
                    pend_rsp = b;
                    pend_v   = 1'b1;
                end
                4'h4: begin
                    n_polls_tx++;
                    chk("tx_poll_has_req", 32'(req_valid != '0), 32'd1);
                    exp_grant = rr_expect(req_valid, model_ptr);
                    if (tx_mode == 0) txbit = ($urandom_range(0, 1) == 1);
                    else if (tx_mode == 2 && tx_block > 0) begin
                        txbit = 1'b0;
                        tx_block--;
                    end else txbit = 1'b1;
                    pend_rsp = {7'($urandom), txbit};
                    pend_v   = 1'b1;
                    if (withdraw_on_poll) en[exp_grant] = 1'b0;
                end
                4'h3: begin
                    n_writes++;
                    after_write = 1'b1;
                    onehot_exp  = NREQ'(1) << exp_grant;
                    chk("req_ready_grant", 32'(req_ready), 32'(onehot_exp));
                    if (txq[exp_grant].size() > 0) begin
                        chk("tx_wdata", 32'(uart_wdata), 32'(txq[exp_grant][0]));
                        void'(txq[exp_grant].pop_front());
                    end else begin
                        chk("tx_grant_had_data", 32'd0, 32'd1);
                    end
                    wlog.push_back(uart_wdata);
                    model_ptr = PW'((int'(exp_grant) + 1) % NREQ);
                    if (n_writes == 1) polls_at_first_write = n_polls_tx;
                end
                default: ;
            endcase
        end else begin
            idle_run++;
        end
        if (!(uart_strobe && uart_addr == 4'h3)) chk("req_ready_idle", 32'(req_ready), 32'd0);

        if (prev_hs) chk("rx_valid_clears", 32'(rx_valid), 32'd0);
        if (rx_valid) begin
            rxv_cycles++;
            if (!prev_rxv) begin
                chk("rx_has_expected", 32'(exp_rx.size() != 0), 32'd1);
                if (exp_rx.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_rx[0]));
            end else begin
                chk("rx_data_hold", 32'(rx_data), 32'(prev_rxd));
            end
        end
        hs = rx_valid && rx_ready;
        if (hs) begin
            n_rx_got++;
            last_rx_byte = rx_data;
            if (exp_rx.size() != 0) void'(exp_rx.pop_front());
        end
        prev_rxv = rx_valid;
        prev_rxd = rx_data;
        prev_hs  = hs;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        uart_rdata = pend_v ? pend_rsp : 8'($urandom);
        pend_v     = 1'b0;
        if (inject_rx && $urandom_range(0, 15) == 0) rxq.push_back(8'($urandom));
        for (int k = 0; k < NREQ; k++) begin
            req_valid[k] = en[k] && (txq[k].size() > 0);
            req_data[k]  = (txq[k].size() > 0) ? txq[k][0] : 8'($urandom);
        end
        rx_ready = (rxr_mode == 2) ? ($urandom_range(0, 1) == 1) : (rxr_mode == 1);
        @(negedge clk);
        observe();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; rx_ready = 1'b0; uart_rdata = 8'h00;
        rxq.delete(); exp_rx.delete(); wlog.delete(); alog.delete();
        for (int k = 0; k < NREQ; k++) txq[k].delete();
        en = '0; model_ptr = '0; exp_grant = '0; pend_v = 1'b0; pend_rsp = 8'h00;
        rx_stuck = 1'b0; withdraw_on_poll = 1'b0; inject_rx = 1'b0;
        tx_mode = 1; tx_block = 0; rxr_mode = 1; idle_run = 0; after_write = 1'b0;
        prev_rxv = 1'b0; prev_hs = 1'b0; prev_rxd = 8'h00; last_rx_byte = 8'h00;
        n_writes = 0; n_polls_tx = 0; n_polls_rx = 0; n_reads = 0; n_rx_got = 0;
        rxv_cycles = 0; polls_at_first_write = -1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found, done;
        int total_tx;

        rst_n = 1'b0; req_valid = '0; req_data = '0; rx_ready = 1'b0; uart_rdata = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_strobe", 32'(uart_strobe), 32'd0);
        chk("rst_addr", 32'(uart_addr), 32'd0);
        chk("rst_wdata", 32'(uart_wdata), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);

        // Single received byte, consumer always ready, no requesters
        do_reset();
        rxq.push_back(8'h5A);
        run(40);
        chk("rx_first_addr", 32'(alog.size() > 0 ? alog[0] : 4'hF), 32'h0);
        chk("rx_second_addr", 32'(alog.size() > 1 ? alog[1] : 4'hF), 32'h1);
        chk("rx_one_read", 32'(n_reads), 32'd1);
        chk("rx_got", 32'(n_rx_got), 32'd1);
        chk("rx_byte", 32'(last_rx_byte), 32'h5A);
        chk("rx_valid_one_cycle", 32'(rxv_cycles), 32'd1);
        chk("rx_polling_resumes", 32'(n_polls_rx >= 3), 32'd1);

        // Two requesters always ready: writes alternate
        do_reset();
        for (int i = 0; i < 6; i++) begin
            txq[0].push_back(8'h41);
            txq[1].push_back(8'h42);
        end
        en = 3'b011;
        run(200);
        chk("alt_write_count", 32'(n_writes), 32'd12);
        for (int i = 0; i < 12; i++)
            chk("alt_write_order", 32'(wlog.size() > i ? wlog[i] : 8'h00), (i % 2 == 1) ? 32'h42 : 32'h41);

        // Transmitter busy for ten polls
        do_reset();
        txq[1].push_back(8'h77);
        en = 3'b010; tx_mode = 2; tx_block = 10;
        run(150);
        chk("busy_polls_before_write", 32'(polls_at_first_write), 32'd11);
        chk("busy_single_write", 32'(n_writes), 32'd1);
        chk("busy_write_data", 32'(wlog.size() > 0 ? wlog[0] : 8'h00), 32'h77);

        // Requester withdraws after the poll
        do_reset();
        txq[2].push_back(8'h33);
        en = 3'b100; withdraw_on_poll = 1'b1;
        run(60);
        chk("withdraw_no_write", 32'(n_writes), 32'd0);
        chk("withdraw_one_poll", 32'(n_polls_tx), 32'd1);

        // RX always ready but consumer stalled; TX keeps flowing
        do_reset();
        rx_stuck = 1'b1; rxr_mode = 0;
        for (int i = 0; i < 5; i++) txq[0].push_back(8'($urandom));
        en = 3'b001;
        run(200);
        chk("stall_one_read", 32'(n_reads), 32'd1);
        chk("stall_tx_writes", 32'(n_writes), 32'd5);
        chk("stall_rx_valid_held", 32'(rx_valid), 32'd1);

        // Asynchronous reset while waiting on TX status
        do_reset();
        txq[0].push_back(8'hC3);
        txq[0].push_back(8'h3C);
        en = 3'b001;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            if (n_writes == 1 && uart_strobe && uart_addr == 4'h4) found = 1'b1;
        end
        chk("poll_tx_reached", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_strobe", 32'(uart_strobe), 32'd0);
        chk("arst_addr", 32'(uart_addr), 32'd0);
        chk("arst_wdata", 32'(uart_wdata), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_rx_valid", 32'(rx_valid), 32'd0);
        chk("arst_rx_data", 32'(rx_data), 32'd0);
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (uart_strobe) found = 1'b1;
        end
        chk("post_reset_strobe_seen", 32'(found), 32'd1);
        chk("post_reset_first_addr", 32'(uart_addr), 32'h0);
        run(30);
        chk("post_reset_no_write", 32'(n_writes), 32'd0);

        // Randomized mixed traffic
        do_reset();
        tx_mode = 0; rxr_mode = 2; inject_rx = 1'b1; en = '1;
        total_tx = 0;
        for (int k = 0; k < NREQ; k++) begin
            int n;
            n = $urandom_range(3, 8);
            total_tx += n;
            for (int i = 0; i < n; i++) txq[k].push_back(8'($urandom));
        end
        for (int i = 0; i < 6; i++) rxq.push_back(8'($urandom));
        run(1500);
        inject_rx = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            cycle();
            done = (txq[0].size() == 0) && (txq[1].size() == 0) && (txq[2].size() == 0) &&
                   (rxq.size() == 0) && (exp_rx.size() == 0) && !rx_valid;
        end
        chk("rand_drained", 32'(done), 32'd1);
        chk("rand_write_count", 32'(n_writes), 32'(total_tx));
        chk("rand_rx_count", 32'(n_rx_got), 32'(n_reads));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
